// File: rtl/expr_stream_parser.sv
// Streaming parser for "<A><op><B><term>" decimal expressions arriving byte-wise
// from a UART receiver; delivers operands, operator and error status to the ALU.
module expr_stream_parser #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       op,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshakes: a byte transfers on a rising edge with rx_valid && rx_ready
    // (bytes offered while rx_ready=0 are lost); a result transfers on a rising
    // edge with out_valid && out_ready, and a/b/op/err/err_code stay frozen
    // while out_valid is high.

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_SYN  = 2'b01;
    localparam logic [1:0] E_OVF  = 2'b10;
    localparam logic [1:0] E_DZ   = 2'b11;
    localparam logic [WIDTH+3:0] TEN     = (WIDTH + 4)'(10);
    localparam logic [WIDTH+3:0] MAX_VAL = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);

    typedef enum logic [1:0] {S_A, S_B, S_ERR, S_HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc_a, acc_b, cur_acc;
    logic [CW-1:0]    cnt_a, cnt_b, cur_cnt;
    logic [2:0]       op_r, op_dec;
    logic [1:0]       pend_err, err_new, code_now;
    logic [WIDTH+3:0] acc_ext;
    logic             accept, is_digit, is_space, is_term, is_op, dig_ovf, div_op;
    logic             acc_we, op_we, err_set, out_load, clr;

    assign accept   = rx_valid && rx_ready;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_space = (rx_data == 8'h20);
    assign is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    assign div_op   = (op_r == 3'b011) || (op_r == 3'b100);

    always_comb begin
        is_op  = 1'b1;
        op_dec = 3'b000;
        case (rx_data)
            8'h2B:   op_dec = 3'b000;
            8'h2D:   op_dec = 3'b001;
            8'h2A:   op_dec = 3'b010;
            8'h2F:   op_dec = 3'b011;
            8'h25:   op_dec = 3'b100;
            default: is_op  = 1'b0;
        endcase
    end

    // The candidate value is formed 4 bits wider so overflow past 2^WIDTH-1 is visible.
    assign cur_acc = (state == S_B) ? acc_b : acc_a;
    assign cur_cnt = (state == S_B) ? cnt_b : cnt_a;
    assign acc_ext = ({4'b0000, cur_acc} * TEN) + {{WIDTH{1'b0}}, rx_data[3:0]};
    assign dig_ovf = (cur_cnt == CNT_MAX) || (acc_ext > MAX_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_A;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_we    = 1'b0;
        op_we     = 1'b0;
        err_set   = 1'b0;
        err_new   = E_NONE;
        out_load  = 1'b0;
        clr       = 1'b0;
        case (state)
            S_A: if (accept && !is_space) begin
                if (is_digit) begin
                    if (dig_ovf) begin
                        err_set = 1'b1; err_new = E_OVF; state_nxt = S_ERR;
                    end else begin
                        acc_we = 1'b1;
                    end
                end else if (is_op) begin
                    if (cnt_a != '0) begin
                        op_we = 1'b1; state_nxt = S_B;
                    end else begin
                        err_set = 1'b1; err_new = E_SYN; state_nxt = S_ERR;
                    end
                end else if (is_term) begin
                    // An empty line is silently ignored.
                    if (cnt_a != '0) begin
                        err_set = 1'b1; err_new = E_SYN; state_nxt = S_HOLD; out_load = 1'b1;
                    end
                end else begin
                    err_set = 1'b1; err_new = E_SYN; state_nxt = S_ERR;
                end
            end
            S_B: if (accept && !is_space) begin
                if (is_digit) begin
                    if (dig_ovf) begin
                        err_set = 1'b1; err_new = E_OVF; state_nxt = S_ERR;
                    end else begin
                        acc_we = 1'b1;
                    end
                end else if (is_term) begin
                    state_nxt = S_HOLD;
                    out_load  = 1'b1;
                    if (cnt_b == '0) begin
                        err_set = 1'b1; err_new = E_SYN;
                    end else if (div_op && acc_b == '0) begin
                        err_set = 1'b1; err_new = E_DZ;
                    end
                end else begin
                    err_set = 1'b1; err_new = E_SYN; state_nxt = S_ERR;
                end
            end
            S_ERR: if (accept && is_term) begin
                state_nxt = S_HOLD;
                out_load  = 1'b1;
            end
            S_HOLD: if (out_ready) begin
                state_nxt = S_A;
                clr       = 1'b1;
            end
            default: state_nxt = S_A;
        endcase
    end

    always_comb begin
        rx_ready  = (state != S_HOLD);
        out_valid = (state == S_HOLD);
    end

    // The earliest recorded error takes precedence over one found at the terminator.
    assign code_now = (pend_err != E_NONE) ? pend_err : (err_set ? err_new : E_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_a    <= '0;
            acc_b    <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            op_r     <= 3'b000;
            pend_err <= E_NONE;
            a        <= '0;
            b        <= '0;
            op       <= 3'b000;
            err      <= 1'b0;
            err_code <= E_NONE;
        end else begin
            if (clr) begin
                acc_a    <= '0;
                acc_b    <= '0;
                cnt_a    <= '0;
                cnt_b    <= '0;
                op_r     <= 3'b000;
                pend_err <= E_NONE;
            end else begin
                if (acc_we && state == S_A) begin
                    acc_a <= acc_ext[WIDTH-1:0];
                    cnt_a <= cnt_a + CNT_ONE;
                end
                if (acc_we && state == S_B) begin
                    acc_b <= acc_ext[WIDTH-1:0];
                    cnt_b <= cnt_b + CNT_ONE;
                end
                if (op_we) op_r <= op_dec;
                if (err_set && pend_err == E_NONE) pend_err <= err_new;
            end
            if (out_load) begin
                err      <= (code_now != E_NONE);
                err_code <= code_now;
                if (code_now == E_SYN || code_now == E_OVF) begin
                    a  <= '0;
                    b  <= '0;
                    op <= 3'b000;
                end else begin
                    a  <= acc_a;
                    b  <= acc_b;
                    op <= op_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_expr_stream_parser.sv
// Bench for expr_stream_parser: directed scenarios plus random expressions, checked
// by a scoreboard fed from a line-level reference model.
module tb_expr_stream_parser;

    localparam int WIDTH = 16;
    localparam int MAXD  = 5;
    localparam int RW    = 1 + 2 + 3 + 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             err;
    logic [1:0]       err_code;
    logic             out_valid;
    logic             out_ready = 1'b0;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               rdy_mode = 0;
    logic [RW-1:0]    exp_q[$];
    logic [7:0]       line_buf[$];

    expr_stream_parser #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .a(a), .b(b), .op(op), .err(err), .err_code(err_code),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic bit is_dig(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic int op_of(input logic [7:0] c);
        case (c)
            8'h2B:   return 0;
            8'h2D:   return 1;
            8'h2A:   return 2;
            8'h2F:   return 3;
            8'h25:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [RW-1:0] pack(input bit e, input logic [1:0] code, input int o,
                                           input longint va, input longint vb);
        logic [2:0]       o3;
        logic [WIDTH-1:0] a16, b16;
        o3  = o[2:0];
        a16 = va[WIDTH-1:0];
        b16 = vb[WIDTH-1:0];
        return {e, code, o3, a16, b16};
    endfunction

    // Evaluates one complete line (spaces already removed, terminator excluded).
    function automatic logic [RW-1:0] model(input logic [7:0] t[$], output bit has_out);
        int     n, p, q, o;
        longint va, vb;
        logic [RW-1:0] syn, ovf;
        syn = pack(1'b1, 2'b01, 0, 0, 0);
        ovf = pack(1'b1, 2'b10, 0, 0, 0);
        n = t.size();
        has_out = (n != 0);
        if (n == 0) return '0;
        p = 0; va = 0;
        while (p < n && is_dig(t[p])) begin
            if (p < 12) va = va * 10 + (int'(t[p]) - 48);
            p++;
        end
        if (p == 0) return syn;
        if (p > MAXD || va > 65535) return ovf;
        if (p == n) return syn;
        o = op_of(t[p]);
        if (o < 0) return syn;
        q = p + 1; vb = 0;
        while (q < n && is_dig(t[q])) begin
            if (q - p < 12) vb = vb * 10 + (int'(t[q]) - 48);
            q++;
        end
        if (q - p - 1 > MAXD || vb > 65535) return ovf;
        if (q < n) return syn;
        if (q - p - 1 == 0) return syn;
        if ((o == 3 || o == 4) && vb == 0) return pack(1'b1, 2'b11, o, va, vb);
        return pack(1'b0, 2'b00, o, va, vb);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] c);
        int w = 0;
        bit has;
        logic [RW-1:0] e;
        while (!rx_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", rx_ready, 1);
            return;
        end
        if (c == 8'h3D || c == 8'h0D) begin
            e = model(line_buf, has);
            if (has) exp_q.push_back(e);
            line_buf.delete();
        end else if (c != 8'h20) begin
            line_buf.push_back(c);
        end
        rx_data  = c;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", {exp_q.size() == 0, !out_valid}, 2'b11);
    endtask

    function automatic string rand_num();
        int    k, len;
        string s;
        k = $urandom_range(0, 9);
        if (k == 0) return "65535";
        if (k == 1) return "65536";
        if (k == 2) return "0";
        len = $urandom_range(1, 6);
        s = "";
        for (int i = 0; i < len; i++) s = $sformatf("%s%c", s, 8'h30 + $urandom_range(0, 9));
        return s;
    endfunction

    function automatic string rand_expr();
        string s, ops, junk;
        int    bad;
        ops  = "+-*/%";
        junk = "x+5 =";
        bad  = $urandom_range(0, 7);
        s = ($urandom_range(0, 4) == 0) ? " " : "";
        if (bad != 1) s = {s, rand_num()};
        if (bad == 2) s = $sformatf("%s%c", s, junk[$urandom_range(0, 4)]);
        if ($urandom_range(0, 3) == 0) s = {s, " "};
        if (bad != 3) s = $sformatf("%s%c", s, ops[$urandom_range(0, 4)]);
        if ($urandom_range(0, 3) == 0) s = {s, " "};
        if (bad != 4) s = {s, ($urandom_range(0, 3) == 0) ? "0" : rand_num()};
        if (bad == 5) s = $sformatf("%s%c", s, junk[$urandom_range(0, 4)]);
        s = {s, ($urandom_range(0, 1) == 0) ? "=" : "\r"};
        return s;
    endfunction

    // ---------------- out_ready generator ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic [RW-1:0] prev_v;
    bit            prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [RW-1:0] cur, e;
        cur = {err, err_code, op, a, b};
        if (rst) begin
            if (prev_stall && out_valid) check("hold_stable", cur, prev_v);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h required none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("result", cur, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_v     = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {a, b, op, err, err_code, out_valid}, '0);
        check("reset_rx_ready", rx_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        rdy_mode = 0;
        @(posedge clk); #1;
        send_str("123+45=", 0);
        check("latency_out_valid", out_valid, 1);
        check("basic_a", a, 123);
        check("basic_b", b, 45);
        check("basic_op", op, 0);
        drain();
        send_str(" 7 - 3 =", 0);
        drain();
        send_str("65535*2\r", 0);
        send_str("65536+1=", 0);
        send_str("000001+1=", 0);
        send_str("12/0=", 0);
        send_str("9%0=", 0);
        drain();
        send_str("+5=5+=5+3+1=5x3=42=2*3=", 0);
        drain();
        send_str("=", 0);
        repeat (4) @(posedge clk);
        #1;
        check("lone_term_no_output", out_valid, 0);

        rdy_mode = 2;
        @(posedge clk); #1;
        send_str("8-2=", 0);
        for (int i = 0; i < 5; i++) begin
            string bp;
            bp = "9+9= ";
            rx_data  = bp[i];
            rx_valid = 1'b1;
            check("bp_rx_ready", rx_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_a_b", {a, b}, {16'd8, 16'd2});
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rdy_mode = 0;
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_second_result", out_valid, 0);

        send_str("12+3", 0);
        rst = 1'b0;
        line_buf.delete();
        #2;
        check("midreset_outputs", {a, b, op, err, err_code, out_valid}, '0);
        check("midreset_rx_ready", rx_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_str("4*5=", 0);
        check("after_reset_a_b_op_err", {a, b, op, err}, {16'd4, 16'd5, 3'b010, 1'b0});
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 80; n++) send_str(rand_expr(), 2);
        rdy_mode = 0;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_stream_parser.md
Name: expr_stream_parser

Overview:
- Parametrised successor to the single-digit ASCII operand/operator front end of the FPGA ALU.
- Consumes a byte stream from the UART receiver. Parses multi-digit unsigned decimal expressions of the form `<A><op><B><term>`.
- Presents A, B and an operator code to the ALU through a valid/ready handshake.
- Adds a fifth operator, whitespace skipping, overflow detection, syntax and divide-by-zero error reporting, and back-pressure toward the receiver.

Parameters:
- WIDTH, 16, operand width in bits; A and B are unsigned, 0 .. 2^WIDTH-1.
- MAX_DIGITS, 5, maximum decimal digits per operand; more digits is an overflow error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  8  ASCII byte from UART receiver
- rx_valid  in  1  rx_data valid for one cycle
- rx_ready  out  1  parser can accept a byte; bytes with rx_valid=1 while rx_ready=0 are dropped
- a  out  WIDTH  operand A
- b  out  WIDTH  operand B
- op  out  3  operator code: 000 `+`, 001 `-`, 010 `*`, 011 `/`, 100 `%`
- err  out  1  expression rejected or flagged
- err_code  out  2  00 none, 01 syntax, 10 overflow, 11 divide-by-zero
- out_valid  out  1  a/b/op/err/err_code valid
- out_ready  in  1  ALU accepts result

Behaviour:

Clock, reset and byte acceptance
- Clock is clk; reset rst is asynchronous, active-low.
- Reset values: a=0, b=0, op=0, err=0, err_code=0, out_valid=0, rx_ready=1, state=S_A, accumulators=0, digit counters=0, pending error=00.
- Reset mid-expression discards all partial data. The first byte after reset starts a new expression.
- A byte is accepted when rx_valid && rx_ready.
- Space (0x20) is ignored in S_A, S_B and S_ERR.
- Terminators are `=` (0x3D) and CR (0x0D).

State machine
- Four states: S_A, S_B, S_ERR, S_HOLD.
- S_A:
  - digit: acc_a <= acc_a*10 + (byte-0x30); cnt_a++.
  - operator char (`+`,`-`,`*`,`/`,`%`) with cnt_a>0: latch op, go to S_B.
  - operator with cnt_a=0: syntax error, go to S_ERR.
  - terminator with cnt_a=0: ignored (empty line).
  - terminator with cnt_a>0: syntax error (missing operator), go directly to S_HOLD.
  - any other byte: syntax error, go to S_ERR.
- S_B:
  - digit: accumulate into acc_b.
  - terminator with cnt_b>0: go to S_HOLD.
  - terminator with cnt_b=0: syntax error, go to S_HOLD.
  - any other byte, including a second operator: syntax error, go to S_ERR.
- S_ERR: discard bytes until a terminator, then go to S_HOLD.
- S_HOLD:
  - rx_ready=0 and out_valid=1.
  - On out_valid && out_ready: out_valid drops next cycle, state returns to S_A, accumulators, counters and pending error clear, rx_ready=1.

Overflow and error rules
- Accumulation is computed in WIDTH+4 bits.
- Overflow (code 10) if the result exceeds 2^WIDTH-1, or if a digit would make cnt exceed MAX_DIGITS. Go to S_ERR; the accumulator is not updated.
- Leading zeros count toward MAX_DIGITS.
- The first error detected wins; later errors in the same expression do not change err_code.
- Divide-by-zero (code 11): op is `/` or `%` with B=0 at the terminator. It is flagged, but a/b/op carry the parsed values.
- Codes 01 and 10 force a=0, b=0, op=0.

Timing
- Latency: terminator accepted in cycle n; out_valid=1 and outputs stable from cycle n+1.
- a/b/op/err/err_code are held constant while out_valid=1 && out_ready=0.
- Outputs keep their last values after the handshake until the next result.
- out_ready asserted while out_valid=0 has no effect.
- A byte arriving in the same cycle as the handshake completes is dropped, because rx_ready=0 in that cycle.

Test Plan:
- "123+45=" at one byte per cycle, out_ready=1: out_valid one cycle after `=`; a=123, b=45, op=000, err=0. Same with spaces " 7 - 3 =": a=7, b=3, op=001.
- "65535*2\r" then "65536+1=": first gives a=65535, b=2, op=010, err=0; second gives err=1, err_code=10, a=b=op=0. "000001+1=" gives err_code=10 (6 digits).
- "12/0=" and "9%0=": err=1, err_code=11, a=12/9, b=0, op=011/100.
- Syntax: "+5=", "5+=", "5+3+1=", "5x3=", "42=" each give err=1, err_code=01 exactly once, then a following "2*3=" gives a=2, b=3, op=010, err=0. A lone "=" produces no output.
- Back-pressure: after "8-2=", hold out_ready=0 for 5 cycles while driving "9+9=". rx_ready=0 throughout; outputs stay a=8, b=2; no second result appears after out_ready=1.
- Reset: assert rst low after "12+3" (no terminator), release, send "4*5=": a=4, b=5, op=010, err=0. All outputs read 0 during reset.
